// File: rtl/riscv_pkg.sv
// riscv_pkg: shared datapath widths, execute-control encodings and the
// operand-forwarding source enumeration used by the issue stage.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int RA_W       = 5;
    localparam int ALU_CNT_W  = 4;
    localparam int COMP_CNT_W = 2;

    // ALU operation encodings carried on ALU_CNT
    localparam logic [ALU_CNT_W-1:0] ALU_ADD   = 4'd0;
    localparam logic [ALU_CNT_W-1:0] ALU_SUB   = 4'd1;
    localparam logic [ALU_CNT_W-1:0] ALU_SLL   = 4'd2;
    localparam logic [ALU_CNT_W-1:0] ALU_SLT   = 4'd3;
    localparam logic [ALU_CNT_W-1:0] ALU_SLTU  = 4'd4;
    localparam logic [ALU_CNT_W-1:0] ALU_XOR   = 4'd5;
    localparam logic [ALU_CNT_W-1:0] ALU_SRL   = 4'd6;
    localparam logic [ALU_CNT_W-1:0] ALU_SRA   = 4'd7;
    localparam logic [ALU_CNT_W-1:0] ALU_OR    = 4'd8;
    localparam logic [ALU_CNT_W-1:0] ALU_AND   = 4'd9;
    localparam logic [ALU_CNT_W-1:0] ALU_PASSB = 4'd10;

    // Branch comparator encodings carried on COMP_CNT
    localparam logic [COMP_CNT_W-1:0] COMP_EQ  = 2'd0;
    localparam logic [COMP_CNT_W-1:0] COMP_NE  = 2'd1;
    localparam logic [COMP_CNT_W-1:0] COMP_LT  = 2'd2;
    localparam logic [COMP_CNT_W-1:0] COMP_LTU = 2'd3;

    typedef enum logic [2:0] {
        FWD_ZERO,
        FWD_EX,
        FWD_MEM,
        FWD_WB,
        FWD_RF
    } fwd_sel_t;

endpackage

// File: rtl/operand_fwd.sv
// operand_fwd: resolves one source operand for the issue stage.
// Picks the newest producer of 'addr' (x0, EX, MEM, WB, register file in
// that priority) and flags a hazard when that producer cannot supply data
// yet (a load sitting in EX, or a MEM writer whose data is still pending).
// Ports:
//   addr, uses, rf_data           source address, use flag, RF read data
//   ex_*                          instruction currently in the issue register
//   mem_valid/pend/rd/data        MEM-stage writer
//   wb_valid/rd/data              WB-stage writer
//   data                          resolved operand value
//   hazard                        source is used and cannot be resolved now
module operand_fwd
    import riscv_pkg::*;
(
    input  logic [RA_W-1:0] addr,
    input  logic            uses,
    input  logic [XLEN-1:0] rf_data,
    input  logic            ex_valid,
    input  logic            ex_writes,
    input  logic            ex_is_load,
    input  logic [RA_W-1:0] ex_rd,
    input  logic [XLEN-1:0] ex_result,
    input  logic            mem_valid,
    input  logic            mem_pend,
    input  logic [RA_W-1:0] mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            wb_valid,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] data,
    output logic            hazard
);

    fwd_sel_t sel;
    logic     addr_nz;

    assign addr_nz = (addr != '0);

    // x0 is checked first, so producers targeting rd=0 can never forward.
    // A load in EX has no result yet; it is skipped here and caught by hazard.
    always_comb begin
        sel = FWD_RF;
        if (!addr_nz)
            sel = FWD_ZERO;
        else if (ex_valid && ex_writes && !ex_is_load && ex_rd == addr)
            sel = FWD_EX;
        else if (mem_valid && mem_rd == addr)
            sel = FWD_MEM;
        else if (wb_valid && wb_rd == addr)
            sel = FWD_WB;
    end

    always_comb begin
        data = rf_data;
        case (sel)
            FWD_ZERO: data = '0;
            FWD_EX:   data = ex_result;
            FWD_MEM:  data = mem_data;
            FWD_WB:   data = wb_data;
            default:  data = rf_data;
        endcase
    end

    assign hazard = uses && addr_nz &&
                    ((ex_valid && ex_is_load && ex_writes && ex_rd == addr) ||
                     (mem_pend && mem_rd == addr));

endmodule

// File: rtl/id_ex_issue.sv
// id_ex_issue: ID/EX issue register with operand forwarding and hazard stall.
// Accepts one decoded instruction per cycle, resolves RS1/RS2 through
// operand_fwd and registers the operands plus execute controls.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   dec_*                          decode-side instruction and handshake
//   rf_ra1/2, rf_rd1/2             register-file read port
//   ex_result                      result of the instruction in the register
//   mem_fwd_*, wb_fwd_*            later-stage writers
//   flush                          drop the issue register and decode instr
//   ex_valid, ex_ready             execute-side handshake
//   *_out                          registered operands and controls
module id_ex_issue
    import riscv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dec_valid,
    output logic                  dec_ready,
    input  logic [XLEN-1:0]       dec_pc,
    input  logic [XLEN-1:0]       dec_imm,
    input  logic [RA_W-1:0]       dec_rs1,
    input  logic [RA_W-1:0]       dec_rs2,
    input  logic [RA_W-1:0]       dec_rd,
    input  logic                  dec_uses_rs1,
    input  logic                  dec_uses_rs2,
    input  logic                  dec_writes_rd,
    input  logic                  dec_is_load,
    input  logic [ALU_CNT_W-1:0]  dec_alu_cnt,
    input  logic [COMP_CNT_W-1:0] dec_comp_cnt,
    input  logic                  dec_mux1_cnt,
    input  logic                  dec_mux2_cnt,
    input  logic                  dec_mux3_cnt,
    output logic [RA_W-1:0]       rf_ra1,
    output logic [RA_W-1:0]       rf_ra2,
    input  logic [XLEN-1:0]       rf_rd1,
    input  logic [XLEN-1:0]       rf_rd2,
    input  logic [XLEN-1:0]       ex_result,
    input  logic                  mem_fwd_valid,
    input  logic                  mem_fwd_pend,
    input  logic [RA_W-1:0]       mem_fwd_rd,
    input  logic [XLEN-1:0]       mem_fwd_data,
    input  logic                  wb_fwd_valid,
    input  logic [RA_W-1:0]       wb_fwd_rd,
    input  logic [XLEN-1:0]       wb_fwd_data,
    input  logic                  flush,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [XLEN-1:0]       pc_out,
    output logic [XLEN-1:0]       rs1_out,
    output logic [XLEN-1:0]       rs2_out,
    output logic [XLEN-1:0]       imm_out,
    output logic [ALU_CNT_W-1:0]  alu_cnt_out,
    output logic [COMP_CNT_W-1:0] comp_cnt_out,
    output logic                  mux1_cnt_out,
    output logic                  mux2_cnt_out,
    output logic                  mux3_cnt_out,
    output logic [RA_W-1:0]       rd_out,
    output logic                  writes_rd_out,
    output logic                  is_load_out
);

    logic [XLEN-1:0] op1, op2;
    logic            haz1, haz2;
    logic            adv;
    logic            accept;

    assign rf_ra1 = dec_rs1;
    assign rf_ra2 = dec_rs2;

    operand_fwd u_fwd_rs1 (
        .addr(dec_rs1), .uses(dec_uses_rs1), .rf_data(rf_rd1),
        .ex_valid(ex_valid), .ex_writes(writes_rd_out), .ex_is_load(is_load_out),
        .ex_rd(rd_out), .ex_result(ex_result),
        .mem_valid(mem_fwd_valid), .mem_pend(mem_fwd_pend),
        .mem_rd(mem_fwd_rd), .mem_data(mem_fwd_data),
        .wb_valid(wb_fwd_valid), .wb_rd(wb_fwd_rd), .wb_data(wb_fwd_data),
        .data(op1), .hazard(haz1)
    );

    operand_fwd u_fwd_rs2 (
        .addr(dec_rs2), .uses(dec_uses_rs2), .rf_data(rf_rd2),
        .ex_valid(ex_valid), .ex_writes(writes_rd_out), .ex_is_load(is_load_out),
        .ex_rd(rd_out), .ex_result(ex_result),
        .mem_valid(mem_fwd_valid), .mem_pend(mem_fwd_pend),
        .mem_rd(mem_fwd_rd), .mem_data(mem_fwd_data),
        .wb_valid(wb_fwd_valid), .wb_rd(wb_fwd_rd), .wb_data(wb_fwd_data),
        .data(op2), .hazard(haz2)
    );

    assign adv = !ex_valid || ex_ready;

    // rst_n gates dec_ready so decode never sees an accept while in reset.
    assign dec_ready = rst_n && adv && !(dec_valid && (haz1 || haz2)) && !flush;
    assign accept    = dec_valid && dec_ready;

    // Issue register: a bubble clears only the qualifying flags; payload holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            writes_rd_out <= 1'b0;
            is_load_out   <= 1'b0;
            pc_out        <= '0;
            rs1_out       <= '0;
            rs2_out       <= '0;
            imm_out       <= '0;
            alu_cnt_out   <= '0;
            comp_cnt_out  <= '0;
            mux1_cnt_out  <= 1'b0;
            mux2_cnt_out  <= 1'b0;
            mux3_cnt_out  <= 1'b0;
            rd_out        <= '0;
        end else if (adv || flush) begin
            if (accept) begin
                ex_valid      <= 1'b1;
                writes_rd_out <= dec_writes_rd;
                is_load_out   <= dec_is_load;
                pc_out        <= dec_pc;
                rs1_out       <= op1;
                rs2_out       <= op2;
                imm_out       <= dec_imm;
                alu_cnt_out   <= dec_alu_cnt;
                comp_cnt_out  <= dec_comp_cnt;
                mux1_cnt_out  <= dec_mux1_cnt;
                mux2_cnt_out  <= dec_mux2_cnt;
                mux3_cnt_out  <= dec_mux3_cnt;
                rd_out        <= dec_rd;
            end else begin
                ex_valid      <= 1'b0;
                writes_rd_out <= 1'b0;
                is_load_out   <= 1'b0;
            end
        end
    end

endmodule

// File: doc/id_ex_issue.md
# id_ex_issue

Operand-issue stage feeding the execute stage: it is the ID/EX pipeline register plus everything needed to produce correct operands for it. It accepts one decoded instruction per cycle from decode, reads the register file, and resolves operands by forwarding from EX, MEM and WB. It detects load-use and not-ready hazards, inserting bubbles where needed. It drives the registered PC/RS1/RS2/IMM and control fields that the execute datapath consumes, using a valid/ready handshake on both sides.

## Interface
- XLEN, 32, datapath width
- RA_W, 5, register address width
- CLK  in  1  clock, all state updates on rising edge
- RST_N  in  1  asynchronous, active-low reset
- DEC_VALID  in  1  decode holds a valid instruction
- DEC_READY  out  1  instruction accepted this cycle (combinational)
- DEC_PC, DEC_IMM  in  XLEN  PC and sign-extended immediate
- DEC_RS1, DEC_RS2, DEC_RD  in  RA_W  source and destination addresses
- DEC_USES_RS1, DEC_USES_RS2, DEC_WRITES_RD, DEC_IS_LOAD  in  1  operand-use and class flags
- DEC_ALU_CNT  in  4; DEC_COMP_CNT  in  2; DEC_MUX1/2/3_CNT  in  1 each  execute controls, passed through
- RF_RA1, RF_RA2  out  RA_W  register-file read addresses (= DEC_RS1/DEC_RS2); RF_RD1, RF_RD2  in  XLEN  combinational read data
- EX_RESULT  in  XLEN  combinational result of the instruction currently in the issue register
- MEM_FWD_VALID, MEM_FWD_PEND  in  1  MEM holds a writer; its data is ready / not yet ready
- MEM_FWD_RD  in  RA_W; MEM_FWD_DATA  in  XLEN
- WB_FWD_VALID  in  1; WB_FWD_RD  in  RA_W; WB_FWD_DATA  in  XLEN
- FLUSH  in  1  discard the issue register and the decode-side instruction
- EX_VALID  out  1  issue register holds a real instruction
- EX_READY  in  1  execute consumes the issue register this cycle
- PC_OUT, RS1_OUT, RS2_OUT, IMM_OUT  out  XLEN  registered operands
- ALU_CNT_OUT  out  4, COMP_CNT_OUT  out  2, MUX1/2/3_CNT_OUT  out  1, RD_OUT  out  RA_W, WRITES_RD_OUT  out  1, IS_LOAD_OUT  out  1  registered controls

## Operation
- adv = !EX_VALID || EX_READY. The issue register loads only when adv=1 or FLUSH=1.
- Operand select, per source, priority high to low:
  - addr==0 → 0
  - EX: EX_VALID && WRITES_RD_OUT && !IS_LOAD_OUT && RD_OUT==addr → EX_RESULT
  - MEM: MEM_FWD_VALID && MEM_FWD_RD==addr → MEM_FWD_DATA
  - WB: WB_FWD_VALID && WB_FWD_RD==addr → WB_FWD_DATA
  - otherwise RF data
- Producers with rd==0 never forward.
- hazard = DEC_VALID && for some used source rs≠0:
  - (EX_VALID && IS_LOAD_OUT && WRITES_RD_OUT && RD_OUT==rs), or
  - (MEM_FWD_PEND && MEM_FWD_RD==rs).
- DEC_READY = adv && !hazard && !FLUSH.
- On an adv edge, the register loads:
  - FLUSH → bubble
  - DEC_VALID && DEC_READY → the instruction with resolved operands
  - otherwise → bubble
- Bubble: EX_VALID=0, WRITES_RD_OUT=0, IS_LOAD_OUT=0; other fields don't-care, implemented as hold.
- A load leaves one bubble behind it. The dependant then takes load data from MEM_FWD_DATA, or keeps stalling while MEM_FWD_PEND=1.
- Unused sources (DEC_USES_RSx=0) never cause a hazard. Their RSx_OUT still carries the forwarded value.

## Timing
- Reset (async, RST_N=0): EX_VALID=0 and all registered outputs 0 immediately. DEC_READY is 0 while in reset.
- Latency: instruction accepted in cycle t appears on the outputs at t+1.
- EX_READY=0 with EX_VALID=1: all outputs hold and DEC_READY=0.
- FLUSH overrides stall and hazard: bubble at the next edge regardless of EX_READY.
- Reset mid-stall clears everything; no hazard state survives.
- Throughput is 1 instruction/cycle absent hazards.

## Structure
- Shared package riscv_pkg holds:
  - ALU_CNT and COMP_CNT encodings and widths
  - RA_W, XLEN
  - enum fwd_sel_t {FWD_ZERO, FWD_EX, FWD_MEM, FWD_WB, FWD_RF}
- Sub-module operand_fwd: source select plus hazard term for one source. Instantiate it twice (RS1, RS2).
- The top level holds the handshake, the issue register and reset.

## Test plan
- Reset: EX_VALID=1, RS1_OUT=0x1234, drop RST_N mid-cycle → outputs 0 before the next edge, DEC_READY=0.
- EX forward: issue holds ADDI x5 with EX_RESULT=0x10; decode reads x5 with RF_RD1=0xDEAD → RS1_OUT=0x10 next cycle, no stall.
- Priority: EX, MEM and WB all write x7 with values 1, 2, 3 → RS2_OUT=1. Drop the EX writer → 2. Drop MEM → 3. Drop WB → RF value.
- Load-use: LW x3 in issue, decode uses x3 → DEC_READY=0 for one cycle and one bubble. Then with MEM_FWD data 0x55 for x3 → RS1_OUT=0x55. With MEM_FWD_PEND=1 for 2 cycles → stall lasts 3 cycles.
- x0: all producers target rd=0 with data 0xFFFFFFFF, decode reads x0 → RS1_OUT=0.
- Backpressure + flush: EX_READY=0 for 3 cycles → outputs stable, DEC_READY=0. FLUSH in the 2nd cycle → EX_VALID=0 at the next edge.
